// File: rtl/sw_out_port.sv
// Egress byte FIFO: stores {last, data}, exposes head and the entry after it, with flush.
// Latency: a pushed entry is visible at head one edge after the push.
// Backpressure: caller gates push_vld with count < DEPTH; flush outranks push and pop.
module sw_out_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop_vld,
  output logic [WIDTH-1:0]       head_dat,
  output logic [WIDTH-1:0]       next_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_nxt;

  assign rd_ptr_nxt = rd_ptr + PW'(1);
  assign head_dat   = mem[rd_ptr];
  assign next_dat   = mem[rd_ptr_nxt];

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + PW'(1);
      if (pop_vld)  rd_ptr <= rd_ptr_nxt;
      case ({push_vld, pop_vld})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Switch output port: buffers whole packets and streams them out byte by byte, one idle cycle between packets.
// Latency: sw_enable_out rises two edges after the last byte of a packet is written into an idle port.
// Backpressure: read_in=1 holds the current byte; wr_full stalls the core, writes while full are dropped.
module sw_out_port #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  input  logic       wr_last,
  output logic       wr_full,
  output logic [7:0] data_out,
  output logic       sw_enable_out,
  input  logic       read_in,
  output logic       err_ovf
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] pkt_cnt;
  logic [8:0]    head_dat;
  logic [8:0]    next_dat;
  logic          wr_acc;
  logic          pop;
  logic          flush;
  logic          discard;
  logic          pkt_rdy;
  logic          start;
  logic          sw_enable_nxt;
  logic [7:0]    data_nxt;

  assign wr_full = (fifo_cnt == CW'(DEPTH));
  // A full FIFO with no complete packet can never drain: drop the oversize packet.
  assign flush   = wr_full && (pkt_cnt == '0);
  assign wr_acc  = wr_en && !wr_full && !discard;
  assign pop     = sw_enable_out && !read_in;
  // pkt_rdy lags pkt_cnt by one edge, giving the two-edge start latency.
  assign start   = pkt_rdy && (pkt_cnt != '0);

  sw_out_fifo #(.WIDTH(9), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push_vld (wr_acc),
    .push_dat ({wr_last, wr_data}),
    .pop_vld  (pop),
    .head_dat (head_dat),
    .next_dat (next_dat),
    .count    (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
      pkt_rdy <= 1'b0;
      discard <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      case ({wr_acc && wr_last, pop && head_dat[8]})
        2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
      pkt_rdy <= (pkt_cnt != '0);
      if ((wr_en && wr_full) || flush) err_ovf <= 1'b1;
      if (flush)                             discard <= !(wr_en && wr_last);
      else if (discard && wr_en && wr_last)  discard <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sw_enable_out <= 1'b0;
      data_out      <= 8'h00;
    end else begin
      state         <= state_nxt;
      sw_enable_out <= sw_enable_nxt;
      data_out      <= data_nxt;
    end
  end

  // In SEND the byte on data_out is still the FIFO head; it is popped on the transfer edge.
  always_comb begin
    state_nxt     = state;
    sw_enable_nxt = sw_enable_out;
    data_nxt      = data_out;
    case (state)
      IDLE, GAP: begin
        if (start) begin
          state_nxt     = SEND;
          sw_enable_nxt = 1'b1;
          data_nxt      = head_dat[7:0];
        end else begin
          state_nxt     = IDLE;
          sw_enable_nxt = 1'b0;
          data_nxt      = 8'h00;
        end
      end
      SEND: begin
        if (!read_in) begin
          if (head_dat[8]) begin
            state_nxt     = GAP;
            sw_enable_nxt = 1'b0;
            data_nxt      = 8'h00;
          end else begin
            data_nxt      = next_dat[7:0];
          end
        end
      end
      default: begin
        state_nxt     = IDLE;
        sw_enable_nxt = 1'b0;
        data_nxt      = 8'h00;
      end
    endcase
  end
endmodule

// File: tb/tb_sw_out_port.sv
// Bench for sw_out_port: directed timing scenarios plus randomized streams against a queue model.
`timescale 1ns/1ps
module tb_sw_out_port;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       wr_last = 1'b0;
  logic       wr_full;
  logic [7:0] data_out;
  logic       sw_enable_out;
  logic       read_in = 1'b0;
  logic       err_ovf;

  int n_cmp = 0;
  int n_fail = 0;

  sw_out_port #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .wr_last       (wr_last),
    .wr_full       (wr_full),
    .data_out      (data_out),
    .sw_enable_out (sw_enable_out),
    .read_in       (read_in),
    .err_ovf       (err_ovf)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic l);
    wr_en = 1'b1; wr_data = d; wr_last = l;
    tick();
    wr_en = 1'b0; wr_data = 8'h00; wr_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({sw_enable_out, data_out, wr_full, err_ovf} !== 11'b0)
      begin n_fail++; $display("FAIL reset_state: en=%b data=%h full=%b ovf=%b, want all 0", sw_enable_out, data_out, wr_full, err_ovf); end
    rst_n = 1'b1;
    // Single-byte packet written on the very first edge after release.
    wr_byte(8'h5A, 1'b1);
    tick();
    n_cmp++;
    if (sw_enable_out !== 1'b0)
      begin n_fail++; $display("FAIL reset_first_e1: en=%b, want 0", sw_enable_out); end
    tick();
    n_cmp++;
    if ({sw_enable_out, data_out} !== {1'b1, 8'h5A})
      begin n_fail++; $display("FAIL reset_first_e2: en=%b data=%h, want en=1 data=5a", sw_enable_out, data_out); end
    tick();
    n_cmp++;
    if ({sw_enable_out, data_out} !== 9'h000)
      begin n_fail++; $display("FAIL reset_first_e3: en=%b data=%h, want en=0 data=00", sw_enable_out, data_out); end
    tick();
  endtask

  task automatic test_basic();
    logic [8:0] exp_seq [5] = '{9'h000, 9'h1A1, 9'h1B2, 9'h1C3, 9'h000};
    wr_byte(8'hA1, 1'b0);
    wr_byte(8'hB2, 1'b0);
    wr_byte(8'hC3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({sw_enable_out, data_out} !== exp_seq[i])
        begin n_fail++; $display("FAIL basic_e%0d: en=%b data=%h, want %h", i + 1, sw_enable_out, data_out, exp_seq[i]); end
    end
    tick();
  endtask

  task automatic test_stall();
    int hold = 0;
    wr_byte(8'hA1, 1'b0);
    wr_byte(8'hB2, 1'b0);
    wr_byte(8'hC3, 1'b1);
    tick();
    tick();
    n_cmp++;
    if ({sw_enable_out, data_out} !== 9'h1A1)
      begin n_fail++; $display("FAIL stall_a1: en=%b data=%h, want 1/a1", sw_enable_out, data_out); end
    tick();
    if ({sw_enable_out, data_out} === 9'h1B2) hold++;
    read_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({sw_enable_out, data_out} !== 9'h1B2)
        begin n_fail++; $display("FAIL stall_hold%0d: en=%b data=%h, want 1/b2", i, sw_enable_out, data_out); end
      else hold++;
    end
    read_in = 1'b0;
    n_cmp++;
    if (hold != 5)
      begin n_fail++; $display("FAIL stall_hold_cycles: got %0d, want 5", hold); end
    tick();
    n_cmp++;
    if ({sw_enable_out, data_out} !== 9'h1C3)
      begin n_fail++; $display("FAIL stall_c3: en=%b data=%h, want 1/c3", sw_enable_out, data_out); end
    tick();
    n_cmp++;
    if ({sw_enable_out, data_out} !== 9'h000)
      begin n_fail++; $display("FAIL stall_end: en=%b data=%h, want 0/00", sw_enable_out, data_out); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] x1, x2, y1;
    logic [8:0] exp_seq [6];
    x1 = 8'($urandom); x2 = 8'($urandom); y1 = 8'($urandom);
    exp_seq = '{9'h000, {1'b1, x1}, {1'b1, x2}, 9'h000, {1'b1, y1}, 9'h000};
    wr_byte(x1, 1'b0);
    wr_byte(x2, 1'b1);
    wr_byte(y1, 1'b1);
    // Sample index 0 is one edge after x2 (the first packet's last byte).
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if ({sw_enable_out, data_out} !== exp_seq[i])
        begin n_fail++; $display("FAIL b2b_s%0d: en=%b data=%h, want %h", i, sw_enable_out, data_out, exp_seq[i]); end
      tick();
    end
    tick();
  endtask

  task automatic test_overflow();
    int en_seen = 0;
    for (int i = 0; i < 16; i++) begin
      wr_byte(8'(8'h10 + i), 1'b0);
      if (sw_enable_out) en_seen++;
      if (i == 14) begin
        n_cmp++;
        if (wr_full !== 1'b0)
          begin n_fail++; $display("FAIL ovf_full15: wr_full=%b, want 0", wr_full); end
      end
    end
    n_cmp++;
    if ({wr_full, err_ovf} !== 2'b10)
      begin n_fail++; $display("FAIL ovf_full16: wr_full=%b ovf=%b, want 1/0", wr_full, err_ovf); end
    wr_byte(8'hEE, 1'b0);
    n_cmp++;
    if ({wr_full, err_ovf} !== 2'b01)
      begin n_fail++; $display("FAIL ovf_flush: wr_full=%b ovf=%b, want 0/1", wr_full, err_ovf); end
    // Closing byte of the oversize packet is still discarded.
    wr_byte(8'hEF, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (sw_enable_out) en_seen++;
      tick();
    end
    n_cmp++;
    if (en_seen != 0)
      begin n_fail++; $display("FAIL ovf_silent: enable seen %0d cycles, want 0", en_seen); end
    wr_byte(8'h3C, 1'b0);
    wr_byte(8'h4D, 1'b1);
    tick();
    tick();
    n_cmp++;
    if ({sw_enable_out, data_out} !== 9'h13C)
      begin n_fail++; $display("FAIL ovf_pkt_b0: en=%b data=%h, want 1/3c", sw_enable_out, data_out); end
    tick();
    n_cmp++;
    if ({sw_enable_out, data_out} !== 9'h14D)
      begin n_fail++; $display("FAIL ovf_pkt_b1: en=%b data=%h, want 1/4d", sw_enable_out, data_out); end
    tick();
    n_cmp++;
    if ({sw_enable_out, data_out, err_ovf} !== 10'b0_0000_0000_1)
      begin n_fail++; $display("FAIL ovf_pkt_end: en=%b data=%h ovf=%b, want 0/00/1", sw_enable_out, data_out, err_ovf); end
    tick();
  endtask

  task automatic test_reset_mid();
    int en_seen = 0;
    wr_byte(8'h61, 1'b0);
    wr_byte(8'h62, 1'b1);
    tick();
    wr_byte(8'h71, 1'b0);
    n_cmp++;
    if ({sw_enable_out, data_out} !== 9'h161)
      begin n_fail++; $display("FAIL rstmid_pre: en=%b data=%h, want 1/61", sw_enable_out, data_out); end
    wr_en = 1'b1; wr_data = 8'h72; wr_last = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sw_enable_out, data_out, wr_full, err_ovf} !== 11'b0)
      begin n_fail++; $display("FAIL rstmid_async: en=%b data=%h full=%b ovf=%b, want all 0", sw_enable_out, data_out, wr_full, err_ovf); end
    wr_en = 1'b0; wr_data = 8'h00;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (sw_enable_out || data_out != 8'h00) en_seen++;
    end
    n_cmp++;
    if (en_seen != 0)
      begin n_fail++; $display("FAIL rstmid_quiet: active cycles %0d, want 0", en_seen); end
    wr_byte(8'h99, 1'b1);
    tick();
    tick();
    n_cmp++;
    if ({sw_enable_out, data_out} !== 9'h199)
      begin n_fail++; $display("FAIL rstmid_new: en=%b data=%h, want 1/99", sw_enable_out, data_out); end
    tick();
    n_cmp++;
    if ({sw_enable_out, data_out} !== 9'h000)
      begin n_fail++; $display("FAIL rstmid_new_end: en=%b data=%h, want 0/00", sw_enable_out, data_out); end
    tick();
  endtask

  task automatic test_stream();
    logic [7:0] exp_q [$];
    logic [7:0] want;
    int sent = 0, got = 0, cyc = 0;
    logic prev_xfer = 1'b0;
    logic xfer;
    while ((sent < 40 || got < 40) && cyc < 3000) begin
      if (prev_xfer) begin
        n_cmp++;
        if (sw_enable_out !== 1'b0)
          begin n_fail++; $display("FAIL stream_gap: en=%b after single-byte packet, want 0", sw_enable_out); end
      end
      if (!sw_enable_out) begin
        n_cmp++;
        if (data_out !== 8'h00)
          begin n_fail++; $display("FAIL stream_idle_data: data=%h while idle, want 00", data_out); end
      end
      read_in = ($urandom_range(0, 2) == 0);
      xfer = sw_enable_out && !read_in;
      if (xfer) begin
        n_cmp++;
        if (exp_q.size() == 0)
          begin n_fail++; $display("FAIL stream_extra: data=%h, want no byte", data_out); end
        else begin
          want = exp_q.pop_front();
          if (data_out !== want)
            begin n_fail++; $display("FAIL stream_order: data=%h, want %h", data_out, want); end
        end
        got++;
      end
      if (sent < 40 && !wr_full) begin
        wr_en = 1'b1; wr_data = 8'(sent); wr_last = 1'b1;
        exp_q.push_back(8'(sent));
        sent++;
      end else begin
        wr_en = 1'b0; wr_last = 1'b0;
      end
      prev_xfer = xfer;
      tick();
      cyc++;
    end
    wr_en = 1'b0; wr_last = 1'b0; wr_data = 8'h00; read_in = 1'b0;
    n_cmp++;
    if (got != 40)
      begin n_fail++; $display("FAIL stream_count: got %0d bytes, want 40", got); end
    tick();
    n_cmp++;
    if ({err_ovf, wr_full} !== 2'b00 || dut.pkt_cnt != 0)
      begin n_fail++; $display("FAIL stream_final: ovf=%b full=%b pkt_cnt=%0d, want 0/0/0", err_ovf, wr_full, dut.pkt_cnt); end
    repeat (2) tick();
  endtask

  task automatic test_random_pkts();
    logic [8:0] src_q [$];
    logic [8:0] exp_q [$];
    logic [8:0] nxt, want;
    logic [7:0] hold_val = 8'h00;
    int n_bytes, got = 0, cyc = 0, n_pkts_wr = 0, n_started = 0;
    logic prev_en = 1'b0, exp_gap = 1'b0, exp_cont = 1'b0, exp_hold = 1'b0;
    for (int p = 0; p < 12; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) src_q.push_back({(b == len - 1), 8'($urandom)});
    end
    n_bytes = src_q.size();
    while (got < n_bytes && cyc < 4000) begin
      if (exp_gap) begin
        n_cmp++;
        if (sw_enable_out !== 1'b0)
          begin n_fail++; $display("FAIL rnd_gap: en=%b after last byte, want 0", sw_enable_out); end
      end
      if (exp_cont) begin
        n_cmp++;
        if (sw_enable_out !== 1'b1)
          begin n_fail++; $display("FAIL rnd_midpkt: en=%b inside packet, want 1", sw_enable_out); end
      end
      if (exp_hold) begin
        n_cmp++;
        if ({sw_enable_out, data_out} !== {1'b1, hold_val})
          begin n_fail++; $display("FAIL rnd_hold: en=%b data=%h, want 1/%h", sw_enable_out, data_out, hold_val); end
      end
      if (sw_enable_out && !prev_en) begin
        n_started++;
        n_cmp++;
        if (n_started > n_pkts_wr)
          begin n_fail++; $display("FAIL rnd_early_start: started %0d, fully written %0d", n_started, n_pkts_wr); end
      end
      read_in = ($urandom_range(0, 3) == 0);
      exp_gap = 1'b0; exp_cont = 1'b0; exp_hold = 1'b0;
      if (sw_enable_out && read_in) begin
        exp_hold = 1'b1;
        hold_val = data_out;
      end else if (sw_enable_out) begin
        n_cmp++;
        if (exp_q.size() == 0)
          begin n_fail++; $display("FAIL rnd_extra: data=%h, want no byte", data_out); end
        else begin
          want = exp_q.pop_front();
          if (data_out !== want[7:0])
            begin n_fail++; $display("FAIL rnd_data: data=%h, want %h", data_out, want[7:0]); end
          if (want[8]) exp_gap = 1'b1;
          else         exp_cont = 1'b1;
        end
        got++;
      end
      wr_en = 1'b0; wr_last = 1'b0;
      if (src_q.size() != 0 && !wr_full && $urandom_range(0, 3) != 0) begin
        nxt = src_q.pop_front();
        wr_en = 1'b1; wr_data = nxt[7:0]; wr_last = nxt[8];
        exp_q.push_back(nxt);
        if (nxt[8]) n_pkts_wr++;
      end
      prev_en = sw_enable_out;
      tick();
      cyc++;
    end
    wr_en = 1'b0; wr_last = 1'b0; wr_data = 8'h00; read_in = 1'b0;
    n_cmp++;
    if (got != n_bytes || err_ovf !== 1'b0)
      begin n_fail++; $display("FAIL rnd_final: got %0d of %0d bytes ovf=%b, want all bytes and ovf=0", got, n_bytes, err_ovf); end
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_stream();
    test_random_pkts();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sw_out_port.md
SW_OUT_PORT -- requirements
Module: sw_out_port

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, byte-FIFO depth (power of 2, >= 4).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 wr_data  input  8  byte from switch core.
REQ-006 wr_en  input  1  write strobe for wr_data.
REQ-007 wr_last  input  1  marks wr_data as final byte of a packet; valid only with wr_en.
REQ-008 wr_full  output  1  FIFO holds DEPTH bytes.
REQ-009 data_out  output  8  serial 1-byte data output toward the port.
REQ-010 sw_enable_out  output  1  data_out valid / packet framing.
REQ-011 read_in  input  1  downstream busy; high stalls transmission.
REQ-012 err_ovf  output  1  sticky overflow flag.

Function
REQ-013 A write SHALL be accepted on any edge with wr_en=1 and wr_full=0; bytes SHALL be stored with their last flag, in order.
REQ-014 wr_full SHALL be 1 exactly when occupancy == DEPTH (combinational from count).
REQ-015 A write with wr_en=1 while wr_full=1 SHALL be dropped and SHALL set err_ovf, which is cleared only by reset.
REQ-016 pkt_cnt SHALL increment on an accepted write with wr_last=1 and decrement when a last byte transfers; both on one edge leaves it unchanged.
REQ-017 A byte transfers on an edge where sw_enable_out=1 and read_in=0; that edge pops the FIFO.
REQ-018 FSM states: IDLE, SEND, GAP; reset state IDLE.
REQ-019 IDLE: if pkt_cnt > 0, register sw_enable_out=1, data_out=FIFO head, go SEND; else stay.
REQ-020 SEND: read_in=1 -> hold data_out and sw_enable_out unchanged; read_in=0 and byte not last -> data_out=next byte, stay; read_in=0 and byte last -> sw_enable_out=0, data_out=8'h00, go GAP.
REQ-021 GAP: sw_enable_out=0 for exactly one cycle; then SEND (loading head as in IDLE) if pkt_cnt > 0, else IDLE.
REQ-022 Transmission SHALL start only for fully buffered packets; sw_enable_out SHALL never deassert mid-packet.
REQ-023 Latency: last byte accepted at edge E with FIFO otherwise empty and FSM in IDLE -> sw_enable_out=1 after edge E+2.
REQ-024 Single-byte packets (wr_en and wr_last together) SHALL be legal: one cycle sw_enable_out=1 when read_in=0.
REQ-025 Write and pop on the same edge SHALL keep occupancy unchanged, including when full (write accepted only if wr_full was 0 before the edge).
REQ-026 If wr_full=1 and pkt_cnt=0 (oversize packet), the FIFO SHALL be flushed on the next edge, setting err_ovf; subsequent bytes up to and including the next wr_last SHALL be discarded.
REQ-027 data_out SHALL be 8'h00 whenever sw_enable_out=0.
REQ-028 Pointers SHALL wrap modulo DEPTH without loss or duplication.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, sw_enable_out=0, data_out=8'h00, err_ovf=0, FIFO empty, wr_full=0, pkt_cnt=0, discard mode off.
REQ-030 Reset mid-packet SHALL abort it; after release no byte of the aborted packet SHALL appear.
REQ-031 After rst_n rises, the first write SHALL be accepted on the first rising edge.

Verification
REQ-032 Write 3 bytes A1,B2,C3 (last on C3), read_in=0 -> sw_enable_out high from edge E+2 for 3 cycles carrying A1,B2,C3, then 0 with data_out=00.
REQ-033 Same packet with read_in=1 for 4 cycles while B2 is on data_out -> B2 held 5 cycles, then C3, no byte lost.
REQ-034 Two back-to-back buffered packets (2 and 1 bytes) -> exactly one idle cycle between them.
REQ-035 Write 17 bytes without wr_last (DEPTH=16) -> wr_full after 16, err_ovf=1, flush, nothing transmitted; following 2-byte packet transmitted intact.
REQ-036 Assert rst_n=0 during second byte of 4-byte packet -> outputs zero immediately; after release, no output until new packet written.
REQ-037 Stream 40 single-byte packets 00..27 with random read_in -> output order 00..27, pkt_cnt returns to 0, err_ovf=0.
